// File: rtl/cpc_io_sequencer_pkg.sv
// Shared types and defaults for the CPC IO sequencer and its write buffer.
// Holds the ATMega handshake state encoding and the default sizing constants.
package lambdaspeak_pkg;

  // STB/ACK handshake towards the ATMega.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESENT  = 2'd1,
    WAIT_REL = 2'd2
  } hs_state_t;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/cpc_io_sequencer_if.sv
// Bus-side and ATMega-side signal bundle of the CPC IO sequencer.
// ATMega side is a 4-phase handshake: the sequencer holds o_ATMEGA_DATA stable, raises
// o_ATMEGA_STB, the ATMega raises i_ATMEGA_ACK once it has taken the byte, the sequencer
// drops STB, and the ATMega drops ACK before the next byte may be presented.
interface cpc_io_sequencer_if;
  import lambdaspeak_pkg::*;

  logic       i_IORQ_N;
  logic       i_WR_N;
  logic       i_RD_N;
  logic       i_ADR_HIT;
  logic [7:0] i_CPC_DATA;
  logic [7:0] o_CPC_DATA;
  logic       o_CPC_DATA_OE;
  logic [7:0] o_ATMEGA_DATA;
  logic       o_ATMEGA_STB;
  logic       i_ATMEGA_ACK;
  logic [7:0] i_ATMEGA_DATA;
  logic       i_ATMEGA_LOAD;
  logic       o_READ_VALID;
  logic       o_FIFO_FULL;
  logic       o_FIFO_EMPTY;
  logic       o_OVERRUN;
  logic       i_CLR_OVERRUN;

  modport slave (
    input  i_IORQ_N, i_WR_N, i_RD_N, i_ADR_HIT, i_CPC_DATA,
    input  i_ATMEGA_ACK, i_ATMEGA_DATA, i_ATMEGA_LOAD, i_CLR_OVERRUN,
    output o_CPC_DATA, o_CPC_DATA_OE, o_ATMEGA_DATA, o_ATMEGA_STB,
    output o_READ_VALID, o_FIFO_FULL, o_FIFO_EMPTY, o_OVERRUN
  );

  modport master (
    output i_IORQ_N, i_WR_N, i_RD_N, i_ADR_HIT, i_CPC_DATA,
    output i_ATMEGA_ACK, i_ATMEGA_DATA, i_ATMEGA_LOAD, i_CLR_OVERRUN,
    input  o_CPC_DATA, o_CPC_DATA_OE, o_ATMEGA_DATA, o_ATMEGA_STB,
    input  o_READ_VALID, o_FIFO_FULL, o_FIFO_EMPTY, o_OVERRUN
  );

endinterface

// File: rtl/cpc_io_sequencer_write_fifo.sv
// DEPTH-entry 8-bit synchronous FIFO; a pop in the same cycle frees room for a push.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module cpc_write_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage is not reset; entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpc_io_sequencer.sv
// Sequencer between the CPC IO decode and the ATMega port: synchronised strobe detection,
// write buffering with a STB/ACK handshake, and a read-back holding register.
module cpc_io_sequencer
  import lambdaspeak_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                i_CLK,
  input  logic                i_RESET_N,
  cpc_io_sequencer_if.slave   bus,
  output hs_state_t           dbg_state
);

  localparam int NSYNC = 6;
  // Reset values put the active-low bus strobes in their inactive state.
  localparam logic [NSYNC-1:0] SYNC_RST = 6'b000111;

  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] sync_out;

  assign async_in = {bus.i_ATMEGA_LOAD, bus.i_ATMEGA_ACK, bus.i_ADR_HIT,
                     bus.i_RD_N, bus.i_WR_N, bus.i_IORQ_N};

  for (genvar g = 0; g < NSYNC; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] sr;
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) sr <= {SYNC_STAGES{SYNC_RST[g]}};
      else            sr <= {sr[SYNC_STAGES-2:0], async_in[g]};
    end
    assign sync_out[g] = sr[SYNC_STAGES-1];
  end

  logic iorq_n_s, wr_n_s, rd_n_s, hit_s, ack_s, load_s;
  assign iorq_n_s = sync_out[0];
  assign wr_n_s   = sync_out[1];
  assign rd_n_s   = sync_out[2];
  assign hit_s    = sync_out[3];
  assign ack_s    = sync_out[4];
  assign load_s   = sync_out[5];

  logic wr_act, rd_act;
  logic wr_act_q, rd_act_q, load_q;
  logic push_req, rd_fall, load_edge;

  assign wr_act    = ~iorq_n_s & ~wr_n_s & hit_s;
  assign rd_act    = ~iorq_n_s & ~rd_n_s & hit_s;
  assign push_req  = wr_act & ~wr_act_q;
  assign rd_fall   = rd_act_q & ~rd_act;
  assign load_edge = load_s & ~load_q;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
      load_q   <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      load_q   <= load_s;
    end
  end

  logic       fifo_full, fifo_empty, pop;
  logic [7:0] fifo_head;

  cpc_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RESET_N),
    .push  (push_req),
    .pop   (pop),
    .din   (bus.i_CPC_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  hs_state_t  state_q, state_d;
  logic       load_data;
  logic [7:0] data_q;
  logic       stb_q;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_data = 1'b1;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          pop     = 1'b1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // STB is only raised on the second PRESENT cycle, one cycle after the data register loads.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_data) data_q <= fifo_head;
      stb_q <= (state_q == PRESENT) && (state_d == PRESENT);
    end
  end

  logic ov_set;
  logic overrun_q;

  assign ov_set = push_req & fifo_full & ~pop;

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N)              overrun_q <= 1'b0;
    else if (ov_set)             overrun_q <= 1'b1;
    else if (bus.i_CLR_OVERRUN)  overrun_q <= 1'b0;
  end

  logic [7:0] hold_q;
  logic       valid_q;
  logic       pend_q;
  logic       apply_load;

  // A load seen during a read is parked as a flag; the byte is taken when it is applied.
  assign apply_load = ~rd_act & (load_edge | pend_q);

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      hold_q  <= 8'h00;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      if (load_edge && rd_act) pend_q <= 1'b1;
      if (apply_load) begin
        hold_q  <= bus.i_ATMEGA_DATA;
        valid_q <= 1'b1;
        pend_q  <= 1'b0;
      end else if (rd_fall) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Drive enable stays combinational on the raw strobes to meet Z80 read timing.
  assign bus.o_CPC_DATA_OE = ~bus.i_IORQ_N & ~bus.i_RD_N & bus.i_ADR_HIT;
  assign bus.o_CPC_DATA    = hold_q;
  assign bus.o_ATMEGA_DATA = data_q;
  assign bus.o_ATMEGA_STB  = stb_q;
  assign bus.o_READ_VALID  = valid_q;
  assign bus.o_FIFO_FULL   = fifo_full;
  assign bus.o_FIFO_EMPTY  = fifo_empty;
  assign bus.o_OVERRUN     = overrun_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_cpc_io_sequencer.sv
// Self-checking bench for cpc_io_sequencer: read-path vector table, hand-written
// handshake/reset sequences and randomized write bursts against a queue model.
module tb_cpc_io_sequencer;
  import lambdaspeak_pkg::*;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic      clk;
  logic      rst_n;
  hs_state_t dbg_state;

  cpc_io_sequencer_if bus ();

  cpc_io_sequencer #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .i_CLK     (clk),
    .i_RESET_N (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];
  bit         ack_en = 1'b0;
  int         ack_dly = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpc_write(input logic [7:0] d, input bit with_ack, input bit with_clr);
    @(negedge clk);
    bus.i_CPC_DATA = d;
    bus.i_ADR_HIT  = 1'b1;
    bus.i_IORQ_N   = 1'b0;
    bus.i_WR_N     = 1'b0;
    if (with_ack) bus.i_ATMEGA_ACK = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (with_clr && k == SYNC)     bus.i_CLR_OVERRUN = 1'b1;
      if (with_clr && k == SYNC + 1) bus.i_CLR_OVERRUN = 1'b0;
    end
    bus.i_IORQ_N  = 1'b1;
    bus.i_WR_N    = 1'b1;
    bus.i_ADR_HIT = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic atmega_load(input logic [7:0] d);
    @(negedge clk);
    bus.i_ATMEGA_DATA = d;
    bus.i_ATMEGA_LOAD = 1'b1;
    repeat (4) @(negedge clk);
    bus.i_ATMEGA_LOAD = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_overrun();
    @(negedge clk);
    bus.i_CLR_OVERRUN = 1'b1;
    @(negedge clk);
    bus.i_CLR_OVERRUN = 1'b0;
    check("overrun_cleared", bus.o_OVERRUN, 1'b0);
  endtask

  // Waits for n handshakes and an idle sequencer, then scores got_q against exp_q.
  task automatic drain_and_score(input string name);
    int n;
    bit done;
    n = exp_q.size();
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (got_q.size() >= n && bus.o_FIFO_EMPTY && dbg_state == IDLE && !bus.i_ATMEGA_ACK)
        done = 1'b1;
    end
    check({name, "_drain_count"}, got_q.size(), n);
    while (exp_q.size() > 0) begin
      if (got_q.size() > 0) check({name, "_byte"}, got_q.pop_front(), exp_q.pop_front());
      else begin
        check({name, "_missing"}, 32'hDEAD, exp_q.pop_front());
      end
    end
    got_q.delete();
  endtask

  // ---------------- ATMega responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (ack_en && bus.o_ATMEGA_STB && !bus.i_ATMEGA_ACK) begin
        got_q.push_back(bus.o_ATMEGA_DATA);
        ack_dly = $urandom_range(0, 3);
        repeat (ack_dly) @(negedge clk);
        bus.i_ATMEGA_ACK = 1'b1;
        begin
          bit released;
          released = 1'b0;
          for (int i = 0; i < 20 && !released; i++) begin
            @(negedge clk);
            if (!bus.o_ATMEGA_STB) released = 1'b1;
          end
          check("responder_stb_release", released, 1'b1);
        end
        bus.i_ATMEGA_ACK = 1'b0;
      end
    end
  end

  // ---------------- read-path vector table ----------------
  typedef struct {
    logic [7:0] first;
    logic       defer;
    logic [7:0] second;
    logic [7:0] exp_during;
    logic [7:0] exp_after;
    logic       exp_valid;
  } rd_vec_t;

  task automatic run_read(input rd_vec_t v, input string name);
    atmega_load(v.first);
    check({name, "_valid_after_load"}, bus.o_READ_VALID, 1'b1);
    @(negedge clk);
    bus.i_ADR_HIT = 1'b1;
    bus.i_IORQ_N  = 1'b0;
    bus.i_RD_N    = 1'b0;
    #1;
    check({name, "_oe_on"}, bus.o_CPC_DATA_OE, 1'b1);
    check({name, "_data_during"}, bus.o_CPC_DATA, v.exp_during);
    repeat (4) @(negedge clk);
    if (v.defer) begin
      atmega_load(v.second);
      check({name, "_data_held"}, bus.o_CPC_DATA, v.exp_during);
    end
    @(negedge clk);
    bus.i_IORQ_N  = 1'b1;
    bus.i_RD_N    = 1'b1;
    bus.i_ADR_HIT = 1'b0;
    #1;
    check({name, "_oe_off"}, bus.o_CPC_DATA_OE, 1'b0);
    repeat (SYNC) @(negedge clk);
    check({name, "_valid_before_clear"}, bus.o_READ_VALID, 1'b1);
    @(negedge clk);
    check({name, "_valid_after"}, bus.o_READ_VALID, v.exp_valid);
    check({name, "_data_after"}, bus.o_CPC_DATA, v.exp_after);
  endtask

  // ---------------- main sequence ----------------
  rd_vec_t rd_tbl[4];

  initial begin
    int t_data, t_stb, cnt;
    bit ov_exp;
    logic [7:0] b;

    rd_tbl[0] = '{8'hA7, 1'b0, 8'h00, 8'hA7, 8'hA7, 1'b0};
    rd_tbl[1] = '{8'hA7, 1'b1, 8'h33, 8'hA7, 8'h33, 1'b1};
    rd_tbl[2] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1};
    rd_tbl[3] = '{8'h5C, 1'b0, 8'hC3, 8'h5C, 8'h5C, 1'b0};

    rst_n = 1'b0;
    bus.i_IORQ_N = 1'b1; bus.i_WR_N = 1'b1; bus.i_RD_N = 1'b1; bus.i_ADR_HIT = 1'b0;
    bus.i_CPC_DATA = 8'h00; bus.i_ATMEGA_ACK = 1'b0; bus.i_ATMEGA_DATA = 8'h00;
    bus.i_ATMEGA_LOAD = 1'b0; bus.i_CLR_OVERRUN = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_cpc_data", bus.o_CPC_DATA, 8'h00);
    check("rst_oe", bus.o_CPC_DATA_OE, 1'b0);
    check("rst_atmega_data", bus.o_ATMEGA_DATA, 8'h00);
    check("rst_stb", bus.o_ATMEGA_STB, 1'b0);
    check("rst_valid", bus.o_READ_VALID, 1'b0);
    check("rst_full", bus.o_FIFO_FULL, 1'b0);
    check("rst_empty", bus.o_FIFO_EMPTY, 1'b1);
    check("rst_overrun", bus.o_OVERRUN, 1'b0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single write: data setup before STB, STB drop after synced ACK.
    t_data = -1; t_stb = -1;
    fork
      cpc_write(8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (bus.o_ATMEGA_DATA == 8'h5A && t_data < 0) t_data = i;
        if (bus.o_ATMEGA_STB && t_stb < 0) t_stb = i;
      end
    join
    check("single_data", bus.o_ATMEGA_DATA, 8'h5A);
    check("single_stb_setup", 32'(t_stb - t_data), 32'd1);
    repeat (10) @(negedge clk);
    bus.i_ATMEGA_ACK = 1'b1;
    cnt = 0;
    while (bus.o_ATMEGA_STB && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("single_stb_drop_latency", cnt, SYNC + 1);
    check("single_empty", bus.o_FIFO_EMPTY, 1'b1);
    bus.i_ATMEGA_ACK = 1'b0;
    repeat (6) @(negedge clk);
    check("single_idle", 32'(dbg_state), 32'(IDLE));

    // Burst into a stalled ATMega: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      cpc_write(8'(i), 1'b0, 1'b0);
      check("burst_full", bus.o_FIFO_FULL, (i >= DEPTH) ? 1'b1 : 1'b0);
      check("burst_overrun", bus.o_OVERRUN, (i > DEPTH) ? 1'b1 : 1'b0);
    end
    // Clear coinciding with a fresh overrun keeps the flag.
    cpc_write(8'h66, 1'b0, 1'b1);
    check("clr_vs_new_overrun", bus.o_OVERRUN, 1'b1);
    clear_overrun();
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
    ack_en = 1'b1;
    drain_and_score("burst");
    ack_en = 1'b0;

    // Full FIFO: pop and push land on the same edge.
    for (int i = 0; i < DEPTH; i++) cpc_write(8'h10 + 8'(i), 1'b0, 1'b0);
    check("popush_pre_full", bus.o_FIFO_FULL, 1'b1);
    cpc_write(8'hE1, 1'b1, 1'b0);
    check("popush_full_again", bus.o_FIFO_FULL, 1'b1);
    check("popush_no_overrun", bus.o_OVERRUN, 1'b0);
    bus.i_ATMEGA_ACK = 1'b0;
    for (int i = 1; i < DEPTH; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'hE1);
    ack_en = 1'b1;
    drain_and_score("popush");
    ack_en = 1'b0;

    // Read path vectors.
    for (int i = 0; i < 4; i++) run_read(rd_tbl[i], $sformatf("rdvec%0d", i));
    @(negedge clk);
    bus.i_IORQ_N = 1'b0; bus.i_RD_N = 1'b0; bus.i_ADR_HIT = 1'b0;
    #1;
    check("oe_needs_hit", bus.o_CPC_DATA_OE, 1'b0);
    bus.i_IORQ_N = 1'b1; bus.i_RD_N = 1'b1;

    // Randomized reads: deferred load must win after the read ends.
    for (int r = 0; r < 6; r++) begin
      rd_vec_t v;
      v.first      = 8'($urandom);
      v.defer      = 1'($urandom_range(0, 1));
      v.second     = 8'($urandom);
      v.exp_during = v.first;
      v.exp_after  = v.defer ? v.second : v.first;
      v.exp_valid  = v.defer;
      run_read(v, $sformatf("rdrand%0d", r));
    end

    // Randomized write bursts against a queue model of a DEPTH-entry buffer.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 7);
      ov_exp = 1'b0;
      model_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        cpc_write(b, 1'b0, 1'b0);
        if (model_q.size() < DEPTH) begin
          model_q.push_back(b);
          exp_q.push_back(b);
        end else ov_exp = 1'b1;
      end
      check("rand_full", bus.o_FIFO_FULL, (model_q.size() == DEPTH) ? 1'b1 : 1'b0);
      check("rand_overrun", bus.o_OVERRUN, ov_exp);
      ack_en = 1'b1;
      drain_and_score($sformatf("rand%0d", r));
      ack_en = 1'b0;
      if (ov_exp) clear_overrun();
    end

    // Reset while presenting.
    for (int i = 0; i < DEPTH + 1; i++) cpc_write(8'hB0 + 8'(i), 1'b0, 1'b0);
    check("rstmid_stb_before", bus.o_ATMEGA_STB, 1'b1);
    check("rstmid_overrun_before", bus.o_OVERRUN, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_stb_async", bus.o_ATMEGA_STB, 1'b0);
    check("rstmid_empty_async", bus.o_FIFO_EMPTY, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_ATMEGA_STB) cnt++;
    end
    check("rstmid_no_stb", cnt, 0);
    check("rstmid_empty", bus.o_FIFO_EMPTY, 1'b1);
    check("rstmid_overrun", bus.o_OVERRUN, 1'b0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    ack_en = 1'b1;
    cpc_write(8'h99, 1'b0, 1'b0);
    exp_q.push_back(8'h99);
    drain_and_score("rstmid_after");
    ack_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpc_io_sequencer.md
Name: cpc_io_sequencer

Overview:
- Clocked sequencer between the CPC IO bus decode and the ATMega data port.
- Replaces edge-latched capture with synchronized strobe detection, a small write FIFO and a 4-phase STB/ACK handshake to the ATMega.
- Also manages a single read-back holding register that the CPC reads at a decoded speech/serial address.
- Sits after the address/mode decoder. It receives a qualified hit, not raw address lines.

Parameters:
DEPTH, 4, write FIFO entries; power of 2, 2..16.
SYNC_STAGES, 2, flip-flop stages on each asynchronous input; at least 2.

Ports:
i_CLK  in  1  system clock, at least 16 MHz (4x the CPC bus clock).
i_RESET_N  in  1  asynchronous active-low reset.
i_IORQ_N  in  1  CPC IORQ, active low, asynchronous.
i_WR_N  in  1  CPC WR, active low, asynchronous.
i_RD_N  in  1  CPC RD, active low, asynchronous.
i_ADR_HIT  in  1  decoded address match, already qualified by the current mode.
i_CPC_DATA  in  8  CPC data bus input.
o_CPC_DATA  out  8  read-back byte to the CPC.
o_CPC_DATA_OE  out  1  CPC data bus drive enable.
o_ATMEGA_DATA  out  8  FIFO head byte.
o_ATMEGA_STB  out  1  byte-valid strobe to the ATMega.
i_ATMEGA_ACK  in  1  ATMega acknowledge, asynchronous.
i_ATMEGA_DATA  in  8  byte to return to the CPC.
i_ATMEGA_LOAD  in  1  ATMega load strobe, asynchronous; active on its rising edge.
o_READ_VALID  out  1  holding register contains an unread byte.
o_FIFO_FULL  out  1  FIFO full.
o_FIFO_EMPTY  out  1  FIFO empty.
o_OVERRUN  out  1  sticky: a CPC write was dropped.
i_CLR_OVERRUN  in  1  synchronous clear of o_OVERRUN.

Behaviour:
Reset values:
- All outputs 0, except o_FIFO_EMPTY=1.
- Pointers 0, FSM in IDLE, holding register 0x00.

Input synchronization:
- i_IORQ_N, i_WR_N, i_RD_N, i_ADR_HIT, i_ATMEGA_ACK and i_ATMEGA_LOAD each pass through SYNC_STAGES flops.
- wr_act = synced IORQ, WR and HIT all active. rd_act is the same with RD in place of WR.

Write capture:
- On the first cycle wr_act goes 0->1, sample i_CPC_DATA and push it. The CPC holds data stable for the whole IORQ cycle.
- Exactly one push per bus cycle. A new push requires wr_act to return to 0 first.
- Write while full: byte is dropped, o_OVERRUN is set, FIFO is unchanged.
- Pop and push in the same cycle while full: the pop takes effect first, so the push is accepted.

Handshake FSM (states IDLE, PRESENT, WAIT_REL):
- IDLE: if the FIFO is not empty, drive o_ATMEGA_DATA = head and go to PRESENT. o_ATMEGA_STB rises the cycle after data is valid, giving at least 1 cycle of setup.
- PRESENT: STB=1; data is held stable. On synced ACK=1: STB=0, pop, go to WAIT_REL.
- WAIT_REL: STB=0. On synced ACK=0, go to IDLE.
- Minimum spacing between STB pulses is 3 cycles plus ACK round-trip latency.
- o_ATMEGA_DATA may change only in IDLE.

Read path:
- o_CPC_DATA_OE = ~i_IORQ_N & ~i_RD_N & i_ADR_HIT. This term is combinational and unsynchronized, to meet Z80 read timing.
- o_CPC_DATA = holding register.
- Load: a synced i_ATMEGA_LOAD rising edge copies i_ATMEGA_DATA and sets o_READ_VALID.
  - If a load arrives while rd_act=1, it is deferred until rd_act falls.
  - A deferred load captures i_ATMEGA_DATA at the moment it is applied.
  - One deferred load is kept; a second one overrides the first.
- Falling edge of rd_act clears o_READ_VALID. A deferred load applied in that same cycle wins: the new byte is loaded and valid stays 1.

Overrun flag:
- i_CLR_OVERRUN and a new overrun in the same cycle: flag stays 1.

Reset mid-operation:
- Asynchronous: STB drops immediately, FIFO is emptied, any deferred load is discarded.

Decomposition:
- Package lambdaspeak_pkg: handshake state enum (IDLE, PRESENT, WAIT_REL), default DEPTH and SYNC_STAGES constants.
- Sub-module cpc_write_fifo: DEPTH-entry, 8-bit synchronous FIFO.
  - Pointers are log2(DEPTH)+1 bits wide, so full = MSB differs and rest equal.
  - Outputs full, empty and head.
  - Reused by a later serial-mode buffer.
- Synchronizer is a local generate loop, not a sub-module.

Test Plan:
1. Single write: CPC writes 0x5A, ACK returns after 10 cycles -> o_ATMEGA_DATA=0x5A, STB high 1 cycle after data valid, STB low 1 cycle after synced ACK, FIFO empty.
2. Burst: 5 writes 0x01..0x05 with ACK held low, DEPTH=4 -> full after 4 writes, 0x05 dropped, o_OVERRUN=1. Release ACK -> ATMega sees 0x01..0x04 in order.
3. Full with simultaneous pop: FIFO full, synced ACK and a new write detected in the same cycle -> write accepted, FIFO full again, no overrun.
4. Read: load 0xA7, then CPC read -> OE high, o_CPC_DATA=0xA7 during the read, o_READ_VALID clears 1 cycle after synced RD release.
5. Load during read: LOAD 0x33 while a read of 0xA7 is in progress -> 0xA7 held through the read, 0x33 present and valid=1 after the read ends.
6. Reset in PRESENT: assert i_RESET_N=0 -> STB=0 asynchronously. After release: empty=1, overrun=0, no STB until a new write.
